// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: multi-cycle shift-add multiplier that borrows the core's
// ALU adder. Returns the low XLEN bits of op_a*op_b with a one-cycle done pulse.
// Optional build macro ALU_MUL_EARLY_TERM_EN: finish as soon as the remaining
// multiplier bits are all zero (results are identical either way).
module alu_mul_sequencer #(
  parameter int              XLEN    = 32,
  parameter int              CNT_W   = 6,
  parameter logic [2:0]      ALU_ADD = 3'b000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  output logic              busy,
  output logic              done,
  output logic [XLEN-1:0]   product,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [2:0]        alu_ctrl,
  input  logic [XLEN-1:0]   alu_result
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [XLEN-1:0]   acc_reg, mcand_reg, mplier_reg, product_reg;
  logic [CNT_W-1:0]  cnt_reg;

  logic              accept;     // start taken this edge (IDLE or DONE)
  logic              step;       // one shift-add iteration commits this edge
  logic              finish;     // RUN -> DONE on this edge
  logic              early_exit; // nothing left to add, skip remaining bits
  logic              last_iter;
  logic [XLEN-1:0]   acc_next;

  // The ALU sum is only taken when the current multiplier bit is set; carry
  // out of the adder is dropped, giving the modulo-2^XLEN product.
  assign acc_next  = mplier_reg[0] ? alu_result : acc_reg;
  assign last_iter = (cnt_reg == CNT_W'(XLEN - 1));

`ifdef ALU_MUL_EARLY_TERM_EN
  assign early_exit = (mplier_reg == '0);
`else
  assign early_exit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and ALU/handshake outputs, all decoded from registers
  always_comb begin
    state_next = ST_IDLE;
    busy       = 1'b0;
    done       = 1'b0;
    alu_a      = '0;
    alu_b      = '0;
    alu_ctrl   = ALU_ADD;
    accept     = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        accept     = start;
        state_next = start ? ST_RUN : ST_IDLE;
      end
      ST_RUN: begin
        busy  = 1'b1;
        alu_a = acc_reg;
        alu_b = mcand_reg;
        if (early_exit) begin
          finish     = 1'b1;
          state_next = ST_DONE;
        end else begin
          step       = 1'b1;
          finish     = last_iter;
          state_next = last_iter ? ST_DONE : ST_RUN;
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        accept     = start;
        state_next = start ? ST_RUN : ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath: operand capture, shift-add iteration, counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
    end else if (accept) begin
      acc_reg    <= '0;
      mcand_reg  <= op_a;
      mplier_reg <= op_b;
      cnt_reg    <= '0;
    end else if (step) begin
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      cnt_reg    <= cnt_reg + CNT_W'(1);
    end
  end

  // Product holds between completions; the final conditional add is included
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      product_reg <= '0;
    end else if (finish) begin
      product_reg <= step ? acc_next : acc_reg;
    end
  end

  assign product = product_reg;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed testbench for alu_mul_sequencer with a behavioural ALU adder.
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] product, alu_a, alu_b, alu_result;
  logic [2:0]  alu_ctrl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // External ALU: add when control selects add, otherwise garbage
  assign alu_result = (alu_ctrl == 3'b000) ? (alu_a + alu_b) : 32'hDEAD_BEEF;

  alu_mul_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .product    (product),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Edges from the start-sampling edge to the edge that enters DONE
  function automatic int lat_of(input logic [31:0] b);
`ifdef ALU_MUL_EARLY_TERM_EN
    int m = -1;
    for (int i = 0; i < 32; i++) if (b[i]) m = i;
    if (m < 0) return 1;
    return (m + 2 > 32) ? 32 : m + 2;
`else
    return 32;
`endif
  endfunction

  // Present operands with start for one edge; operands scrambled afterwards
  task automatic do_start(input logic [31:0] a, input logic [31:0] b, input string tag);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    @(posedge clk); #1;
    start = 1'b0;
    op_a  = $urandom;
    op_b  = $urandom;
    check_val({tag, "_busy"}, {31'd0, busy}, 32'd1);
  endtask

  // Wait (bounded) for done; n0 = edges already elapsed since start edge
  task automatic wait_done(input logic [31:0] exp, input int lat, input int n0, input string tag);
    int n = n0;
    bit got = 0;
    while (!got && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (done) got = 1;
    end
    check_val({tag, "_lat"}, 32'(n), 32'(lat));
    check_val({tag, "_prod"}, product, exp);
    check_val({tag, "_busy0"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int p;
    int dc;
    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk); #1;
    check_val("rst_busy",  {31'd0, busy}, 32'd0);
    check_val("rst_done",  {31'd0, done}, 32'd0);
    check_val("rst_prod",  product, 32'd0);
    check_val("rst_alu_a", alu_a, 32'd0);
    check_val("rst_alu_b", alu_b, 32'd0);
    check_val("rst_ctrl",  {29'd0, alu_ctrl}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 3*5 with a look at the ALU drive on the first iteration
    do_start(32'd3, 32'd5, "m3x5");
    check_val("m3x5_alu_a0", alu_a, 32'd0);
    check_val("m3x5_alu_b0", alu_b, 32'd3);
    @(posedge clk); #1;
    check_val("m3x5_alu_a1", alu_a, 32'd3);
    check_val("m3x5_alu_b1", alu_b, 32'd6);
    wait_done(32'd15, lat_of(32'd5), 1, "m3x5");
    @(posedge clk); #1;
    check_val("m3x5_done1cyc", {31'd0, done}, 32'd0);
    check_val("idle_alu_a", alu_a, 32'd0);

    // Wrap-around cases
    do_start(32'hFFFF_FFFF, 32'hFFFF_FFFF, "wrapff");
    wait_done(32'd1, lat_of(32'hFFFF_FFFF), 0, "wrapff");
    @(posedge clk); #1;
    do_start(32'h8000_0000, 32'd2, "wrap80");
    wait_done(32'd0, lat_of(32'd2), 0, "wrap80");
    @(posedge clk); #1;

    // Early-termination boundary operands (same products either build)
    do_start(32'd9, 32'd0, "b0");
    wait_done(32'd0, lat_of(32'd0), 0, "b0");
    @(posedge clk); #1;
    do_start(32'd5, 32'd1, "b1");
    wait_done(32'd5, lat_of(32'd1), 0, "b1");
    @(posedge clk); #1;

    // start during RUN is ignored
    do_start(32'd7, 32'd6, "ign");
    p = (lat_of(32'd6) > 12) ? 10 : 1;
    repeat (p - 1) begin @(posedge clk); #1; end
    start = 1'b1; op_a = 32'd9; op_b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(32'd42, lat_of(32'd6), p, "ign");
    count_done(40, dc);
    check_val("ign_no2nd", 32'(dc), 32'd0);

    // Reset mid-RUN aborts without a done pulse
    do_start(32'd7, 32'd6, "rstrun");
    p = (lat_of(32'd6) > 14) ? 11 : 1;
    repeat (p) begin @(posedge clk); #1; end
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check_val("rstrun_busy", {31'd0, busy}, 32'd0);
    check_val("rstrun_prod", product, 32'd0);
    check_val("rstrun_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    count_done(40, dc);
    check_val("rstrun_nodone", 32'(dc), 32'd0);
    do_start(32'd4, 32'd4, "m4x4");
    wait_done(32'd16, lat_of(32'd4), 0, "m4x4");
    @(posedge clk); #1;

    // Back-to-back: start held in the DONE cycle
    do_start(32'd2, 32'd3, "b2b1");
    wait_done(32'd6, lat_of(32'd3), 0, "b2b1");
    start = 1'b1; op_a = 32'd10; op_b = 32'd10;
    @(posedge clk); #1;
    start = 1'b0; op_a = $urandom; op_b = $urandom;
    check_val("b2b2_busy", {31'd0, busy}, 32'd1);
    check_val("b2b2_hold", product, 32'd6);
    wait_done(32'd100, lat_of(32'd10), 0, "b2b2");
    @(posedge clk); #1;
    check_val("b2b2_idle", {31'd0, done | busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
